// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the memory PC port and buffers returned words in a
// 2-entry skid FIFO so decode can stall without losing or duplicating instructions.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          WORD_ADDRESSED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_pc_address,
    input  logic [31:0] mem_pc_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned_redirect
);

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // Handshake: the head entry is offered while instr_valid=1 and is consumed at the
    // clock edge of any cycle with instr_valid=1 and stall=0; it is held otherwise.
    fifo_state_e count_q, count_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [31:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
    logic [31:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;
    logic        misaligned_q, misaligned_d;

    logic        pop;
    logic        issue;
    logic [2:0]  occupancy;

    assign instr_valid         = (count_q != FIFO_EMPTY);
    assign instr               = e0_instr_q;
    assign instr_pc            = e0_pc_q;
    assign misaligned_redirect = misaligned_q;
    assign mem_pc_address      = WORD_ADDRESSED ? {2'b00, fetch_pc_q[31:2]} : fetch_pc_q;

    always_comb begin
        pop       = instr_valid & ~stall;
        // Words that will still be held after this edge if a new fetch goes out now.
        occupancy = {1'b0, count_q} + {2'b00, resp_valid_q} - {2'b00, pop};
        issue     = ~redirect_valid & (occupancy <= 3'd1);

        count_d      = count_q;
        fetch_pc_d   = fetch_pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        e0_instr_d   = e0_instr_q;
        e0_pc_d      = e0_pc_q;
        e1_instr_d   = e1_instr_q;
        e1_pc_d      = e1_pc_q;
        misaligned_d = 1'b0;

        if (redirect_valid) begin
            count_d      = FIFO_EMPTY;
            resp_valid_d = 1'b0;
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            misaligned_d = |redirect_pc[1:0];
        end else begin
            resp_valid_d = issue;
            if (issue) begin
                resp_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            case ({resp_valid_q, pop})
                2'b10: begin
                    if (count_q == FIFO_EMPTY) begin
                        e0_instr_d = mem_pc_data;
                        e0_pc_d    = resp_pc_q;
                        count_d    = FIFO_ONE;
                    end else if (count_q == FIFO_ONE) begin
                        e1_instr_d = mem_pc_data;
                        e1_pc_d    = resp_pc_q;
                        count_d    = FIFO_FULL;
                    end
                end
                2'b01: begin
                    e0_instr_d = e1_instr_q;
                    e0_pc_d    = e1_pc_q;
                    count_d    = (count_q == FIFO_FULL) ? FIFO_ONE : FIFO_EMPTY;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy unchanged, queue shifts forward.
                    if (count_q == FIFO_ONE) begin
                        e0_instr_d = mem_pc_data;
                        e0_pc_d    = resp_pc_q;
                    end else begin
                        e0_instr_d = e1_instr_q;
                        e0_pc_d    = e1_pc_q;
                        e1_instr_d = mem_pc_data;
                        e1_pc_d    = resp_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= FIFO_EMPTY;
            fetch_pc_q   <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'd0;
            e0_instr_q   <= 32'd0;
            e0_pc_q      <= 32'd0;
            e1_instr_q   <= 32'd0;
            e1_pc_q      <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            e0_instr_q   <= e0_instr_d;
            e0_pc_q      <= e0_pc_d;
            e1_instr_q   <= e1_instr_d;
            e1_pc_q      <= e1_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    push_never_overflows: assert property (@(posedge clk) disable iff (!rst)
        !(resp_valid_q && !pop && !redirect_valid && count_q == FIFO_FULL));

endmodule
